ccd_pixel_reader: RTL and testbench

Receive-side counterpart of the linear-CCD timing generator. It watches the CCD_ICG integration-clear gate and frames the ADC sample stream of each readout into one line. Per line it skips the leading dummy elements, estimates the dark level from the shielded elements, and emits the dark-subtracted active pixels as an indexed stream. It sits between the CCD output ADC and the line buffer / sugar-estimation logic.

---
 rtl/ccd_pixel_reader.sv | 168 ++++++++++++++++
 tb/tb_ccd_pixel_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_pixel_reader.sv
`default_nettype none
// ============================================================================
//  Module   : ccd_pixel_reader
//  Purpose  : Frames one linear-CCD readout line from the ADC strobe stream,
//             estimates the dark level from shielded elements, and emits
//             dark-subtracted, indexed active pixels.
//  Revision : 1.0 - initial release
// ============================================================================
module ccd_pixel_reader #(
  parameter int ADC_W      = 12,
  parameter int TOTAL_PIX  = 3694,
  parameter int LEAD_DUMMY = 32,
  parameter int ACTIVE_PIX = 3648,
  parameter int DARK_START = 16,
  parameter int DARK_LOG2  = 3
) (
  input  logic             Master_clk,
  input  logic             rst,
  input  logic             ccd_icg,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic [ADC_W-1:0] pix_data,
  output logic [11:0]      pix_index,
  output logic             pix_valid,
  output logic             pix_sof,
  output logic             pix_eof,
  output logic [ADC_W-1:0] dark_level,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err
);

  localparam int CNT_W    = $clog2(TOTAL_PIX);
  localparam int ACC_W    = ADC_W + DARK_LOG2;
  localparam int DARK_CNT = 1 << DARK_LOG2;

  localparam logic [CNT_W-1:0] DARK_LO   = CNT_W'(DARK_START);
  localparam logic [CNT_W-1:0] DARK_HI   = CNT_W'(DARK_START + DARK_CNT);
  localparam logic [CNT_W-1:0] LEAD_CNT  = CNT_W'(LEAD_DUMMY);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(LEAD_DUMMY - 1);
  localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(ACTIVE_PIX - 1);
  localparam logic [CNT_W-1:0] TOT_LAST  = CNT_W'(TOTAL_PIX - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SKIP   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_TAIL   = 2'd3
  } state_t;

  state_t           state;
  logic             icg_q;
  logic [CNT_W-1:0] elem_cnt;
  logic [ACC_W-1:0] acc;

  logic             icg_rise;
  logic             icg_fall;
  logic             in_dark;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] act_idx;
  logic [ADC_W-1:0] sub_pix;

  // Edge detection on the integration-clear gate
  assign icg_rise = ccd_icg & ~icg_q;
  assign icg_fall = ~ccd_icg & icg_q;

  // Dark window membership and running sum including the current sample
  assign in_dark  = (elem_cnt >= DARK_LO) && (elem_cnt < DARK_HI);
  assign acc_next = in_dark ? (acc + ACC_W'(adc_data)) : acc;

  // Active pixel index and floored dark subtraction
  assign act_idx  = elem_cnt - LEAD_CNT;
  assign sub_pix  = (adc_data >= dark_level) ? (adc_data - dark_level) : '0;

  // Line framing state machine with registered outputs
  always_ff @(posedge Master_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      icg_q      <= 1'b1;
      elem_cnt   <= '0;
      acc        <= '0;
      pix_data   <= '0;
      pix_index  <= '0;
      pix_valid  <= 1'b0;
      pix_sof    <= 1'b0;
      pix_eof    <= 1'b0;
      dark_level <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      icg_q      <= ccd_icg;
      pix_valid  <= 1'b0;
      pix_sof    <= 1'b0;
      pix_eof    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (icg_rise) begin
            elem_cnt <= '0;
            acc      <= '0;
            busy     <= 1'b1;
            state    <= ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (icg_fall) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (adc_valid) begin
            elem_cnt <= elem_cnt + 1'b1;
            acc      <= acc_next;
            if (elem_cnt == LEAD_LAST) begin
              dark_level <= ADC_W'(acc_next >> DARK_LOG2);
              state      <= ST_ACTIVE;
            end
          end
        end
        ST_ACTIVE: begin
          if (icg_fall) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (adc_valid) begin
            elem_cnt  <= elem_cnt + 1'b1;
            pix_valid <= 1'b1;
            pix_index <= 12'(act_idx);
            pix_data  <= sub_pix;
            pix_sof   <= (act_idx == '0);
            if (act_idx == ACT_LAST) begin
              pix_eof <= 1'b1;
              // No tail elements: the last active pixel also closes the line
              if (elem_cnt == TOT_LAST) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state      <= ST_IDLE;
              end else begin
                state <= ST_TAIL;
              end
            end
          end
        end
        ST_TAIL: begin
          if (icg_fall) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (adc_valid) begin
            elem_cnt <= elem_cnt + 1'b1;
            if (elem_cnt == TOT_LAST) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccd_pixel_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ccd_pixel_reader
//  Purpose  : Directed self-checking bench for ccd_pixel_reader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ccd_pixel_reader;

  logic        Master_clk = 1'b0;
  logic        rst;
  logic        ccd_icg;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [11:0] pix_data;
  logic [11:0] pix_index;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_eof;
  logic [11:0] dark_level;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  ccd_pixel_reader dut (
    .Master_clk (Master_clk),
    .rst        (rst),
    .ccd_icg    (ccd_icg),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .pix_data   (pix_data),
    .pix_index  (pix_index),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_eof    (pix_eof),
    .dark_level (dark_level),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 Master_clk = ~Master_clk;

  int checks = 0;
  int fails  = 0;

  // Cycle counter, stepped on every rising edge
  int cyc = 0;
  always @(posedge Master_clk) cyc <= cyc + 1;

  // Pixel expectation per data pattern: 0 = flat 1000 over dark 100,
  // 1 = ramp dark (level 28) with samples 20 and 4095 at indices 0 and 1
  int exp_mode = 0;
  function automatic logic [11:0] exp_data(input int mode, input logic [11:0] idx);
    if (mode == 0) return 12'd900;
    if (idx == 12'd0) return 12'd0;
    if (idx == 12'd1) return 12'd4067;
    return 12'd972;
  endfunction

  function automatic logic [11:0] elem_data(input int mode, input int e);
    if (e >= 16 && e < 24) return (mode == 0) ? 12'd100 : 12'((e - 16) * 8);
    if (mode == 1 && e == 32) return 12'd20;
    if (mode == 1 && e == 33) return 12'd4095;
    return 12'd1000;
  endfunction

  // Output monitor: counts pulses and flags ordering/data deviations
  int          pv_count = 0, sof_count = 0, eof_count = 0;
  int          done_count = 0, err_count = 0;
  int          idx_bad = 0, data_bad = 0, sof_bad = 0, eof_bad = 0, stray = 0;
  int          sof_cyc = 0, eof_cyc = 0, done_cyc = 0;
  logic [11:0] last_idx = 12'd0;
  always @(negedge Master_clk) begin
    if (pix_valid) begin
      pv_count <= pv_count + 1;
      if (pix_index !== (pix_sof ? 12'd0 : last_idx + 12'd1)) idx_bad <= idx_bad + 1;
      last_idx <= pix_index;
      if (pix_data !== exp_data(exp_mode, pix_index)) data_bad <= data_bad + 1;
      if (pix_sof) begin
        sof_count <= sof_count + 1;
        sof_cyc   <= cyc;
        if (pix_index !== 12'd0) sof_bad <= sof_bad + 1;
      end
      if (pix_eof) begin
        eof_count <= eof_count + 1;
        eof_cyc   <= cyc;
        if (pix_index !== 12'd3647) eof_bad <= eof_bad + 1;
      end
    end else if (pix_sof || pix_eof) begin
      stray <= stray + 1;
    end
    if (frame_done) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
    end
    if (frame_err) err_count <= err_count + 1;
  end

  int s32_cyc  = 0;
  int last_cyc = 0;

  task automatic tick();
    @(posedge Master_clk);
    #1;
  endtask

  task automatic start_line();
    ccd_icg = 1'b0;
    tick();
    tick();
    ccd_icg = 1'b1;
    tick();
  endtask

  // Strobe elements 0..last_elem, one every gap cycles (gap 1 = back-to-back)
  task automatic drive_line(input int mode, input int gap, input int last_elem);
    for (int e = 0; e <= last_elem; e++) begin
      adc_valid = 1'b1;
      adc_data  = elem_data(mode, e);
      if (e == 32) s32_cyc = cyc + 1;
      if (e == last_elem) last_cyc = cyc + 1;
      tick();
      if (gap > 1) begin
        adc_valid = 1'b0;
        repeat (gap - 1) tick();
      end
    end
    adc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ccd_icg = 1'b0; adc_valid = 1'b0; adc_data = 12'd0;
    repeat (3) tick();
    checks++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_pix_valid: got %0b want 0", pix_valid); end
    checks++; if (pix_data !== 12'd0) begin fails++; $display("FAIL reset_pix_data: got %0d want 0", pix_data); end
    checks++; if (dark_level !== 12'd0) begin fails++; $display("FAIL reset_dark: got %0d want 0", dark_level); end
    checks++; if ({busy, frame_done, frame_err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {busy, frame_done, frame_err}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_strobes();
    int pv0 = pv_count;
    drive_line(0, 2, 19);
    repeat (2) tick();
    checks++; if (pv_count - pv0 !== 0) begin fails++; $display("FAIL idle_no_pixels: got %0d want 0", pv_count - pv0); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_full_line();
    int pv0 = pv_count, ib0 = idx_bad, db0 = data_bad, d0 = done_count, s0 = sof_count, e0 = eof_count;
    exp_mode = 0;
    start_line();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL line_busy: got %0b want 1", busy); end
    drive_line(0, 4, 3693);
    repeat (2) tick();
    checks++; if (dark_level !== 12'd100) begin fails++; $display("FAIL line_dark: got %0d want 100", dark_level); end
    checks++; if (pv_count - pv0 !== 3648) begin fails++; $display("FAIL line_pix_count: got %0d want 3648", pv_count - pv0); end
    checks++; if (idx_bad - ib0 !== 0) begin fails++; $display("FAIL line_index_order: got %0d bad want 0", idx_bad - ib0); end
    checks++; if (data_bad - db0 !== 0) begin fails++; $display("FAIL line_pix_data: got %0d bad want 0", data_bad - db0); end
    checks++; if (sof_count - s0 !== 1 || eof_count - e0 !== 1) begin fails++; $display("FAIL line_sof_eof: got %0d/%0d want 1/1", sof_count - s0, eof_count - e0); end
    checks++; if (done_count - d0 !== 1) begin fails++; $display("FAIL line_done_count: got %0d want 1", done_count - d0); end
    checks++; if (done_cyc !== last_cyc) begin fails++; $display("FAIL line_done_latency: got cycle %0d want %0d", done_cyc, last_cyc); end
    checks++; if (pix_index !== 12'd3647 || pix_data !== 12'd900) begin fails++; $display("FAIL line_hold: got idx %0d data %0d want 3647 900", pix_index, pix_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL line_idle_after: got %0b want 0", busy); end
    ccd_icg = 1'b0;
  endtask

  task automatic test_dark_floor();
    int pv0 = pv_count, db0 = data_bad;
    exp_mode = 1;
    start_line();
    drive_line(1, 2, 3693);
    repeat (2) tick();
    checks++; if (dark_level !== 12'd28) begin fails++; $display("FAIL dark_ramp_level: got %0d want 28", dark_level); end
    checks++; if (data_bad - db0 !== 0) begin fails++; $display("FAIL dark_floor_data: got %0d bad want 0", data_bad - db0); end
    checks++; if (pv_count - pv0 !== 3648) begin fails++; $display("FAIL dark_pix_count: got %0d want 3648", pv_count - pv0); end
    ccd_icg = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pv0 = pv_count, d0 = done_count, ib0 = idx_bad;
    exp_mode = 0;
    start_line();
    drive_line(0, 1, 3693);
    repeat (2) tick();
    checks++; if (pv_count - pv0 !== 3648) begin fails++; $display("FAIL b2b_pix_count: got %0d want 3648", pv_count - pv0); end
    checks++; if (sof_cyc !== s32_cyc) begin fails++; $display("FAIL b2b_first_latency: got cycle %0d want %0d", sof_cyc, s32_cyc); end
    checks++; if (eof_cyc - sof_cyc !== 3647) begin fails++; $display("FAIL b2b_contiguous: got span %0d want 3647", eof_cyc - sof_cyc); end
    checks++; if (idx_bad - ib0 !== 0) begin fails++; $display("FAIL b2b_index_order: got %0d bad want 0", idx_bad - ib0); end
    checks++; if (done_count - d0 !== 1 || done_cyc !== last_cyc) begin fails++; $display("FAIL b2b_done: got %0d at %0d want 1 at %0d", done_count - d0, done_cyc, last_cyc); end
    checks++; if (stray !== 0) begin fails++; $display("FAIL b2b_stray_flags: got %0d want 0", stray); end
    ccd_icg = 1'b0;
  endtask

  task automatic test_abort();
    int pv0 = pv_count, d0 = done_count, e0 = err_count, ib0 = idx_bad, s0 = sof_count;
    exp_mode = 0;
    start_line();
    drive_line(0, 2, 2000);
    ccd_icg = 1'b0;
    tick();
    checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL abort_err_pulse: got %0b want 1", frame_err); end
    tick();
    checks++; if (frame_err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL abort_after: got err %0b busy %0b want 0 0", frame_err, busy); end
    drive_line(0, 1, 9);
    repeat (2) tick();
    checks++; if (pv_count - pv0 !== 1969) begin fails++; $display("FAIL abort_pix_count: got %0d want 1969", pv_count - pv0); end
    checks++; if (err_count - e0 !== 1 || done_count - d0 !== 0) begin fails++; $display("FAIL abort_pulses: got err %0d done %0d want 1 0", err_count - e0, done_count - d0); end
    pv0 = pv_count;
    start_line();
    drive_line(0, 1, 3693);
    repeat (2) tick();
    checks++; if (pv_count - pv0 !== 3648) begin fails++; $display("FAIL abort_recover_count: got %0d want 3648", pv_count - pv0); end
    checks++; if (idx_bad - ib0 !== 0 || sof_count - s0 !== 2) begin fails++; $display("FAIL abort_recover_index: got bad %0d sof %0d want 0 2", idx_bad - ib0, sof_count - s0); end
    checks++; if (done_count - d0 !== 1) begin fails++; $display("FAIL abort_recover_done: got %0d want 1", done_count - d0); end
    ccd_icg = 1'b0;
  endtask

  task automatic test_rst_midline();
    int d0, e0;
    exp_mode = 0;
    start_line();
    drive_line(0, 1, 500);
    checks++; if (busy !== 1'b1 || pix_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_state: got busy %0b valid %0b want 1 1", busy, pix_valid); end
    d0 = done_count; e0 = err_count;
    rst = 1'b1;
    tick();
    checks++; if ({pix_valid, pix_sof, pix_eof, busy, frame_done, frame_err} !== 6'b0) begin fails++; $display("FAIL rst_flags: got %b want 000000", {pix_valid, pix_sof, pix_eof, busy, frame_done, frame_err}); end
    checks++; if (pix_data !== 12'd0 || pix_index !== 12'd0 || dark_level !== 12'd0) begin fails++; $display("FAIL rst_data: got %0d %0d %0d want 0 0 0", pix_data, pix_index, dark_level); end
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (done_count - d0 !== 0 || err_count - e0 !== 0 || busy !== 1'b0) begin fails++; $display("FAIL rst_no_pulse: got done %0d err %0d busy %0b want 0 0 0", done_count - d0, err_count - e0, busy); end
    ccd_icg = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_strobes();
    test_full_line();
    test_dark_floor();
    test_back_to_back();
    test_abort();
    test_rst_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
